instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 88 ++++++++
 tb/tb_instruction_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register with exception/interrupt/redirect/stall
// priority, combinational ROM address, and the IF/ID pipeline register.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  input  logic        exception,
  output logic [30:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] irq_epc
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] epc_q, epc_d;

  logic [31:0] pc_seq;
  logic        irq_take;
  logic        flush;

  // Bit 31 is the supervisor bit: it never reaches the ROM and survives increments.
  assign pc_seq   = {pc_q[31], pc_q[30:0] + 31'd4};
  assign irq_take = irq & ~pc_q[31];
  assign flush    = exception | irq_take | redirect;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    epc_d   = epc_q;

    if (exception)     pc_d = EXC_VECTOR;
    else if (irq_take) pc_d = IRQ_VECTOR;
    else if (redirect) pc_d = redirect_pc;
    else if (!stall)   pc_d = pc_seq;

    // Any control transfer overrides stall and squashes the fetched word.
    if (flush) begin
      instr_d = 32'd0;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (!stall) begin
      instr_d = rom_data;
      pc4_d   = pc_seq;
      valid_d = 1'b1;
    end

    if (irq_take && !exception) epc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      epc_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      epc_q   <= epc_d;
    end
  end

  assign rom_addr    = pc_q[30:0];
  assign pc          = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign irq_epc     = epc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized + directed bench for instruction_fetch: driver pushes the model's
// expected post-edge state into exp_q; a monitor pops and compares after each edge.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irq;
  logic        exception;
  logic [30:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] irq_epc;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .irq         (irq),
    .exception   (exception),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .irq_epc     (irq_epc)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- ROM: 64 words at byte address 0..255, zero beyond ----------------
  logic [31:0] rom [64];

  function automatic logic [31:0] rom_word(input logic [30:0] a);
    if (a[30:8] == 23'd0) return rom[a[7:2]];
    return 32'd0;
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  // ---------------- reference model ----------------
  // Expected entry layout: {pc, instr, pc4, valid, epc}
  localparam int EW = 129;
  logic [EW-1:0] exp_q[$];

  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_valid;

  function automatic logic [31:0] next_seq(input logic [31:0] p);
    logic [31:0] low;
    low = ((p & 32'h7FFF_FFFF) + 32'd4) & 32'h7FFF_FFFF;
    return (p & 32'h8000_0000) | low;
  endfunction

  function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc, input logic iq, input logic ex);
    logic        take;
    logic [31:0] fetched;
    logic [31:0] old_pc;
    @(negedge clk);
    reset = r; stall = s; redirect = rd; redirect_pc = rpc; irq = iq; exception = ex;
    old_pc  = m_pc;
    fetched = rom_word(m_pc[30:0]);
    take    = iq && (m_pc[31] == 1'b0);
    if (r) begin
      m_pc = 32'h8000_0000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_epc = 0;
    end else begin
      if (ex || take || rd) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (!s) begin
        m_instr = fetched; m_pc4 = next_seq(old_pc); m_valid = 1;
      end
      if (take && !ex) m_epc = old_pc;
      if (ex)        m_pc = 32'h8000_0008;
      else if (take) m_pc = 32'h8000_0004;
      else if (rd)   m_pc = rpc;
      else if (!s)   m_pc = next_seq(old_pc);
    end
    exp_q.push_back({m_pc, m_instr, m_pc4, m_valid, m_epc});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'd0, 0, 0);
  endtask

  task automatic after_edge();
    @(posedge clk); #2;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check32("pc",       pc,                  e[128:97]);
        check32("instr",    if_id_instr,         e[96:65]);
        check32("pc4",      if_id_pc4,           e[64:33]);
        check32("valid",    {31'd0, if_id_valid}, {31'd0, e[32]});
        check32("irq_epc",  irq_epc,             e[31:0]);
        check32("rom_addr", {1'b0, rom_addr},    {1'b0, e[127:97]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; stall = 0; redirect = 0; redirect_pc = 0; irq = 0; exception = 0;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h2004_0054;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_epc = 0;

    // Reset two cycles, then free run
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    after_edge();
    check32("rst_pc", pc, 32'h8000_0000);
    check32("rst_valid", {31'd0, if_id_valid}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    after_edge();
    check32("first_instr", if_id_instr, 32'h2004_0054);
    check32("first_pc4", if_id_pc4, 32'h8000_0004);
    check32("first_valid", {31'd0, if_id_valid}, 32'd1);
    check32("first_pc", pc, 32'h8000_0004);
    run(3);

    // Stall 3 cycles at 0x80000010
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0);
    after_edge();
    check32("stall_pc", pc, 32'h8000_0010);
    cycle(0, 0, 0, 0, 0, 0);
    after_edge();
    check32("stall_release_pc", pc, 32'h8000_0014);

    // Redirect during stall
    cycle(0, 1, 1, 32'h8000_0030, 0, 0);
    after_edge();
    check32("redir_stall_pc", pc, 32'h8000_0030);
    check32("redir_stall_valid", {31'd0, if_id_valid}, 32'd0);
    check32("redir_stall_instr", if_id_instr, 32'd0);

    // Interrupt in user mode, then masked in supervisor mode
    cycle(0, 0, 1, 32'h0000_0040, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    after_edge();
    check32("irq_pc", pc, 32'h8000_0004);
    check32("irq_epc", irq_epc, 32'h0000_0040);
    check32("irq_valid", {31'd0, if_id_valid}, 32'd0);
    cycle(0, 0, 1, 32'h8000_0040, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    after_edge();
    check32("irq_masked_pc", pc, 32'h8000_0044);
    check32("irq_masked_valid", {31'd0, if_id_valid}, 32'd1);

    // Exception beats irq and redirect
    cycle(0, 0, 1, 32'h0000_0020, 0, 0);
    cycle(0, 0, 1, 32'h0000_0100, 1, 1);
    after_edge();
    check32("exc_pc", pc, 32'h8000_0008);
    check32("exc_epc", irq_epc, 32'h0000_0040);
    check32("exc_valid", {31'd0, if_id_valid}, 32'd0);

    // Wrap within bits 30:0, beyond-ROM NOP
    cycle(0, 0, 1, 32'h7FFF_FFFC, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    after_edge();
    check32("wrap_pc", pc, 32'h0000_0000);
    check32("wrap_nop_instr", if_id_instr, 32'd0);
    check32("wrap_nop_valid", {31'd0, if_id_valid}, 32'd1);

    // Reset during redirect
    cycle(1, 1, 1, 32'h0000_0080, 0, 0);
    after_edge();
    check32("rst_redir_pc", pc, 32'h8000_0000);
    check32("rst_redir_valid", {31'd0, if_id_valid}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 23'd0, 6'($urandom_range(0, 63)), 2'b00};
      cycle($urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 19) < 3,
            rpc,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0);
    end
    cycle(0, 0, 0, 0, 0, 0);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
